// File: rtl/pick_pkg.sv
// Shared constants and FSM state encoding for the pick cursor driver.
package pick_pkg;
    localparam int BAND_BASE  = 39;
    localparam int BAND_PITCH = 14;
    localparam int NUM_BANDS  = 32;
    localparam int MAX_BAND   = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_ARRIVE
    } pick_state_e;
endpackage

// File: rtl/band_centre.sv
// Band index to centre pixel: 39 + 14*k, built from shifts.
module band_centre
    import pick_pkg::*;
(
    input  logic [4:0] k_i,
    output logic [9:0] centre_o
);
    logic [9:0] kx;

    assign kx       = {5'b0, k_i};
    assign centre_o = 10'(BAND_BASE) + (kx << 4) - (kx << 1);
endmodule

// File: rtl/pick_cursor_driver.sv
// Slews the pick cursor Y toward the centre of a target band, one
// STEP per frame tick, with retargeting and a one-cycle arrival pulse.
module pick_cursor_driver
    import pick_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       up_press,
    input  logic       down_press,
    input  logic       load_valid,
    input  logic [4:0] load_band,
    input  logic       hold,
    output logic [9:0] pickY,
    output logic [4:0] target_band,
    output logic [4:0] cur_band,
    output logic       moving,
    output logic       arrived
);
    pick_state_e state_q;
    logic [9:0]  pick_y_q;
    logic [4:0]  tgt_q;
    logic [4:0]  tgt_d;
    logic [4:0]  cur_q;
    logic        moving_q;
    logic        arrived_q;
    logic        upd;
    logic [9:0]  centre;
    logic [9:0]  diff;
    logic [9:0]  step_y;
    logic        at_ctr;

    band_centre u_centre (
        .k_i      (tgt_q),
        .centre_o (centre)
    );

    // Presses that would not change the target are not updates.
    always_comb begin
        tgt_d = tgt_q;
        upd   = 1'b0;
        if (load_valid) begin
            tgt_d = load_band;
            upd   = 1'b1;
        end else if (up_press && !down_press) begin
            if (tgt_q != 5'd0) begin
                tgt_d = tgt_q - 5'd1;
                upd   = 1'b1;
            end
        end else if (down_press && !up_press) begin
            if (tgt_q != 5'(MAX_BAND)) begin
                tgt_d = tgt_q + 5'd1;
                upd   = 1'b1;
            end
        end
    end

    // Clamp to the centre when within one step so we never overshoot.
    always_comb begin
        at_ctr = (pick_y_q == centre);
        diff   = '0;
        step_y = pick_y_q;
        if (pick_y_q < centre) begin
            diff   = centre - pick_y_q;
            step_y = (diff <= 10'(STEP)) ? centre : pick_y_q + 10'(STEP);
        end else if (pick_y_q > centre) begin
            diff   = pick_y_q - centre;
            step_y = (diff <= 10'(STEP)) ? centre : pick_y_q - 10'(STEP);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            pick_y_q  <= 10'(BAND_BASE);
            tgt_q     <= '0;
            cur_q     <= '0;
            moving_q  <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            arrived_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (upd) begin
                        state_q  <= ST_MOVE;
                        moving_q <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (at_ctr && !upd) begin
                        state_q   <= ST_ARRIVE;
                        moving_q  <= 1'b0;
                        arrived_q <= 1'b1;
                        cur_q     <= tgt_q;
                    end else if (frame_tick && !hold) begin
                        pick_y_q <= step_y;
                    end
                end
                ST_ARRIVE: begin
                    state_q  <= upd ? ST_MOVE : ST_IDLE;
                    moving_q <= upd;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign pickY       = pick_y_q;
    assign target_band = tgt_q;
    assign cur_band    = cur_q;
    assign moving      = moving_q;
    assign arrived     = arrived_q;
endmodule
